// File: rtl/up_bus_responder_pkg.sv
// Shared constants for the microprocessor data-bus responder.
// Phase encodings and bus widths used by the top and debounce files.
package up_bus_responder_pkg;

    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

    localparam int DW = 4;
    localparam int AW = 12;

endpackage

// File: rtl/up_bus_responder_btn.sv
// Per-bit button conditioner: 2-flop synchronizer plus optional
// stability counter (enabled with DEBOUNCE_EN).
module btn_debounce
    import up_bus_responder_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic state
);

    logic syncA;
    logic syncB;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= raw;
            syncB <= syncA;
        end
    end

`ifdef DEBOUNCE_EN
    localparam logic [3:0] CNT_MAX = 4'(DEB_CYCLES - 1);

    logic [3:0] cnt;
    logic       stateQ;

    // Count consecutive samples that disagree with the held value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stateQ <= 1'b0;
        end else if (syncB == stateQ) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt    <= '0;
            stateQ <= syncB;
        end else if (cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign state = stateQ;
`else
    localparam int unusedDebCycles = DEB_CYCLES;

    assign state = syncB;
`endif

endmodule

// File: rtl/up_bus_responder.sv
// Data RAM, output latch and pushbutton port for a 4-bit processor bus.
// Define DEBOUNCE_EN to filter the buttons with a stability counter.
module up_bus_responder
    import up_bus_responder_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          phase,
    input  logic          cs,
    input  logic          we,
    input  logic          oeIn,
    input  logic          loadOut,
    input  logic [AW-1:0] address_RAM,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] pushbuttons,
    output logic [DW-1:0] data_bus,
    output logic [DW-1:0] FF_out,
    output logic [DW-1:0] btn_state,
    output logic          bus_conflict
);

    logic [DW-1:0]     mem [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] ramIdx;
    logic [AW-1:0]     unusedAddr;

    logic execOk;
    logic doWrite;
    logic rdSel;
    logic btnSel;
    logic conflict;

    // Upper address bits alias onto the same RAM words.
    assign ramIdx     = address_RAM[RAM_AW-1:0];
    assign unusedAddr = address_RAM;

    assign execOk   = (phase == PH_EXEC) && !reset;
    assign doWrite  = execOk && cs && we;
    assign conflict = oeIn && cs && !we;
    assign rdSel    = cs && !we && !oeIn;
    assign btnSel   = oeIn && !(cs && !we);

    always_ff @(posedge clock) begin
        if (doWrite) begin
            mem[ramIdx] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            FF_out       <= '0;
            bus_conflict <= 1'b0;
        end else begin
            if (execOk && loadOut) begin
                FF_out <= wr_data;
            end
            if (conflict) begin
                bus_conflict <= 1'b1;
            end
        end
    end

    always_comb begin
        data_bus = '0;
        unique case (1'b1)
            conflict: data_bus = '0;
            rdSel:    data_bus = mem[ramIdx];
            btnSel:   data_bus = btn_state;
            default:  data_bus = '0;
        endcase
    end

    for (genvar i = 0; i < DW; i++) begin : gBtn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) uDeb (
            .clk  (clock),
            .reset(reset),
            .raw  (pushbuttons[i]),
            .state(btn_state[i])
        );
    end

endmodule

// File: tb/tb_up_bus_responder.sv
// Directed self-checking bench for up_bus_responder.
// Button latency expectation follows the DEBOUNCE_EN build option.
module tb_up_bus_responder;

    localparam int DEB = 4;
`ifdef DEBOUNCE_EN
    localparam int BTN_LAT = 2 + DEB;
`else
    localparam int BTN_LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        phase;
    logic        cs;
    logic        we;
    logic        oeIn;
    logic        loadOut;
    logic [11:0] address_RAM;
    logic [3:0]  wr_data;
    logic [3:0]  pushbuttons;
    logic [3:0]  data_bus;
    logic [3:0]  FF_out;
    logic [3:0]  btn_state;
    logic        bus_conflict;

    int nTests = 0;
    int nFail  = 0;

    always #5 clock = ~clock;

    up_bus_responder #(.RAM_AW(8), .DEB_CYCLES(DEB)) dut (
        .clock       (clock),
        .reset       (reset),
        .phase       (phase),
        .cs          (cs),
        .we          (we),
        .oeIn        (oeIn),
        .loadOut     (loadOut),
        .address_RAM (address_RAM),
        .wr_data     (wr_data),
        .pushbuttons (pushbuttons),
        .data_bus    (data_bus),
        .FF_out      (FF_out),
        .btn_state   (btn_state),
        .bus_conflict(bus_conflict)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        phase   = 1'b0;
        cs      = 1'b0;
        we      = 1'b0;
        oeIn    = 1'b0;
        loadOut = 1'b0;
    endtask

    task automatic ramWrite(input logic [11:0] a, input logic [3:0] d,
                            input logic ph);
        idle();
        phase       = ph;
        cs          = 1'b1;
        we          = 1'b1;
        address_RAM = a;
        wr_data     = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        idle();
        address_RAM = '0;
        wr_data     = '0;
        pushbuttons = '0;
        step();
        step();
        reset = 1'b0;
        nTests++;
        if (FF_out !== 4'h0) begin
            nFail++;
            $display("FAIL reset_ff_out got %h want 0", FF_out);
        end
        nTests++;
        if (btn_state !== 4'h0 || bus_conflict !== 1'b0) begin
            nFail++;
            $display("FAIL reset_btn_conf got %h/%b want 0/0",
                     btn_state, bus_conflict);
        end
        nTests++;
        if (data_bus !== 4'h0) begin
            nFail++;
            $display("FAIL idle_bus got %h want 0", data_bus);
        end
    endtask

    task automatic test_ram();
        ramWrite(12'h005, 4'hA, 1'b1);
        cs          = 1'b1;
        address_RAM = 12'h005;
        #1;
        nTests++;
        if (data_bus !== 4'hA) begin
            nFail++;
            $display("FAIL ram_read got %h want a", data_bus);
        end
        ramWrite(12'h105, 4'h3, 1'b1);
        cs          = 1'b1;
        address_RAM = 12'h005;
        #1;
        nTests++;
        if (data_bus !== 4'h3) begin
            nFail++;
            $display("FAIL ram_alias got %h want 3", data_bus);
        end
        ramWrite(12'h005, 4'hF, 1'b0);
        cs          = 1'b1;
        address_RAM = 12'hF05;
        #1;
        nTests++;
        if (data_bus !== 4'h3) begin
            nFail++;
            $display("FAIL ram_fetch_wr got %h want 3", data_bus);
        end
        reset = 1'b1;
        ramWrite(12'h005, 4'h9, 1'b1);
        reset       = 1'b0;
        cs          = 1'b1;
        address_RAM = 12'h005;
        #1;
        nTests++;
        if (data_bus !== 4'h3) begin
            nFail++;
            $display("FAIL ram_reset_wr got %h want 3", data_bus);
        end
        // Write in progress: old data visible before the edge, new after.
        ramWrite(12'h020, 4'h1, 1'b1);
        phase       = 1'b1;
        cs          = 1'b1;
        we          = 1'b1;
        address_RAM = 12'h020;
        wr_data     = 4'hC;
        #1;
        we = 1'b0;
        #1;
        nTests++;
        if (data_bus !== 4'h1) begin
            nFail++;
            $display("FAIL ram_old_data got %h want 1", data_bus);
        end
        we = 1'b1;
        step();
        we = 1'b0;
        #1;
        nTests++;
        if (data_bus !== 4'hC) begin
            nFail++;
            $display("FAIL ram_new_data got %h want c", data_bus);
        end
        idle();
    endtask

    task automatic test_latch();
        wr_data = 4'h6;
        loadOut = 1'b1;
        phase   = 1'b0;
        step();
        nTests++;
        if (FF_out !== 4'h0) begin
            nFail++;
            $display("FAIL latch_fetch got %h want 0", FF_out);
        end
        phase = 1'b1;
        step();
        idle();
        wr_data = 4'h2;
        step();
        nTests++;
        if (FF_out !== 4'h6) begin
            nFail++;
            $display("FAIL latch_exec got %h want 6", FF_out);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nTests++;
        if (FF_out !== 4'h0) begin
            nFail++;
            $display("FAIL latch_reset got %h want 0", FF_out);
        end
    endtask

    task automatic test_buttons();
        oeIn        = 1'b1;
        pushbuttons = 4'b0101;
        for (int i = 0; i < BTN_LAT - 1; i++) begin
            step();
        end
        nTests++;
        if (data_bus !== 4'h0) begin
            nFail++;
            $display("FAIL btn_early got %h want 0", data_bus);
        end
        step();
        nTests++;
        if (data_bus !== 4'h5) begin
            nFail++;
            $display("FAIL btn_value got %h want 5", data_bus);
        end
        // Write with oeIn high: buttons drive the bus, write still lands.
        phase       = 1'b1;
        cs          = 1'b1;
        we          = 1'b1;
        address_RAM = 12'h010;
        wr_data     = 4'h7;
        #1;
        nTests++;
        if (data_bus !== 4'h5) begin
            nFail++;
            $display("FAIL wr_oe_bus got %h want 5", data_bus);
        end
        step();
        idle();
        cs          = 1'b1;
        address_RAM = 12'h010;
        #1;
        nTests++;
        if (data_bus !== 4'h7 || bus_conflict !== 1'b0) begin
            nFail++;
            $display("FAIL wr_oe_ram got %h/%b want 7/0",
                     data_bus, bus_conflict);
        end
        idle();
    endtask

    task automatic test_bounce();
`ifdef DEBOUNCE_EN
        pushbuttons = 4'b0000;
        for (int i = 0; i < BTN_LAT + 2; i++) begin
            step();
        end
        pushbuttons = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        pushbuttons = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step();
            nTests++;
            if (btn_state !== 4'h0) begin
                nFail++;
                $display("FAIL bounce cyc %0d got %h want 0", i, btn_state);
            end
        end
`endif
    endtask

    task automatic test_conflict();
        phase       = 1'b1;
        cs          = 1'b1;
        we          = 1'b0;
        oeIn        = 1'b1;
        address_RAM = 12'h005;
        #1;
        nTests++;
        if (data_bus !== 4'h0 || bus_conflict !== 1'b0) begin
            nFail++;
            $display("FAIL conf_pre got %h/%b want 0/0",
                     data_bus, bus_conflict);
        end
        step();
        nTests++;
        if (bus_conflict !== 1'b1) begin
            nFail++;
            $display("FAIL conf_set got %b want 1", bus_conflict);
        end
        idle();
        step();
        step();
        nTests++;
        if (bus_conflict !== 1'b1) begin
            nFail++;
            $display("FAIL conf_sticky got %b want 1", bus_conflict);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nTests++;
        if (bus_conflict !== 1'b0) begin
            nFail++;
            $display("FAIL conf_reset got %b want 0", bus_conflict);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_latch();
        test_buttons();
        test_bounce();
        test_conflict();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/up_bus_responder.md
UP_BUS_RESPONDER -- requirements
Module: up_bus_responder

Interface
REQ-001 Parameter RAM_AW, default 8, SHALL set data-RAM address width; depth is 2^RAM_AW nibbles.
REQ-002 Parameter DEB_CYCLES, default 4, SHALL set the debounce stability count in clock cycles (range 2..15).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 phase  input  1  SHALL be the processor phase: 0 = fetch, 1 = execute.
REQ-006 cs  input  1  SHALL be the data-RAM chip select.
REQ-007 we  input  1  SHALL be the data-RAM write enable (1 = write, 0 = read).
REQ-008 oeIn  input  1  SHALL request the pushbutton value on data_bus.
REQ-009 loadOut  input  1  SHALL request a load of the output latch.
REQ-010 address_RAM  input  12  SHALL be the processor data address.
REQ-011 wr_data  input  4  SHALL be the processor write and output data (accumulator value).
REQ-012 pushbuttons  input  4  SHALL be the raw asynchronous button inputs.
REQ-013 data_bus  output  4  SHALL be the read data returned to the processor.
REQ-014 FF_out  output  4  SHALL be the output latch value.
REQ-015 btn_state  output  4  SHALL be the filtered button value.
REQ-016 bus_conflict  output  1  SHALL be a sticky error flag.

Function
REQ-017 RAM write SHALL occur at a rising edge where cs=1, we=1 and phase=1: mem[address_RAM[RAM_AW-1:0]] <= wr_data.
REQ-018 Address bits above RAM_AW SHALL be ignored, so addresses alias and wrap modulo 2^RAM_AW.
REQ-019 RAM read SHALL be combinational: when cs=1, we=0 and oeIn=0, data_bus = mem[address_RAM[RAM_AW-1:0]] with zero-cycle latency, in either phase.
REQ-020 When oeIn=1 and cs=0, data_bus SHALL equal btn_state.
REQ-021 When neither source is selected, data_bus SHALL be 4'h0; the block SHALL have no tri-state outputs.
REQ-022 When oeIn=1 and (cs=1 with we=0), data_bus SHALL be 4'h0 and bus_conflict SHALL set on that edge.
REQ-023 bus_conflict SHALL then remain 1 until reset.
REQ-024 When cs=1, we=1 and oeIn=1 occur together, the write SHALL still occur, data_bus SHALL equal btn_state, and no conflict SHALL be flagged.
REQ-025 FF_out SHALL load wr_data at a rising edge where loadOut=1 and phase=1, and SHALL hold otherwise.
REQ-026 Write, read and loadOut requests SHALL be ignored for state-changing purposes while phase=0.
REQ-027 pushbuttons SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-028 A write and a read to the same address in one cycle SHALL return the old content; the new value becomes visible from the next cycle.

Reset
REQ-029 While reset=1 at an edge, the block SHALL clear FF_out, btn_state, the synchronizer flops, the debounce counters and bus_conflict to 0.
REQ-030 While reset=1, RAM writes and loadOut SHALL be suppressed.
REQ-031 RAM contents SHALL NOT be cleared by reset and are undefined until written.
REQ-032 An operation in progress when reset asserts SHALL be abandoned with no partial update.

Configuration
REQ-033 With DEBOUNCE_EN defined, each btn_state bit SHALL change only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles.
REQ-034 With DEBOUNCE_EN defined, the per-bit counter SHALL restart from 0 on any sample equal to btn_state, and SHALL saturate rather than wrap.
REQ-035 Without DEBOUNCE_EN, btn_state SHALL equal the synchronizer output, giving 2 cycles of latency, and no counters SHALL be instantiated.

Structure
REQ-036 A shared package SHALL hold: the phase encodings (PH_FETCH=0, PH_EXEC=1), the data width constant DW=4, and the processor address width AW=12.
REQ-037 Debounce SHALL be one sub-module, btn_debounce, instantiated per bit (synchronizer plus counter), with the counter guarded by DEBOUNCE_EN.

Verification
REQ-038 Write test: write 0xA to address 0x005 at phase=1, then read with cs=1, we=0 -> data_bus=0xA in the same cycle.
REQ-039 Alias test: write 0x3 at 0x105, then read 0x005 -> data_bus=0x3 (RAM_AW=8).
REQ-040 Output latch test: loadOut=1 with wr_data=0x6 at phase=0 -> FF_out unchanged; at phase=1 -> FF_out=0x6 next cycle; then reset -> FF_out=0x0.
REQ-041 Button test: pushbuttons 0000->0101 held, oeIn=1 -> data_bus=0x5 after 2 cycles without DEBOUNCE_EN, or after 2+DEB_CYCLES cycles with it.
REQ-042 Bounce test: with DEBOUNCE_EN, a 3-cycle glitch 0->1->0 on bit 0 -> btn_state[0] stays 0.
REQ-043 Conflict test: cs=1, we=0, oeIn=1 -> data_bus=0x0 and bus_conflict=1; bus_conflict stays 1 after the stimulus clears, and returns to 0 only after reset.
